// File: rtl/rotary_cells_pkg.sv
// Shared types and valve encodings for the rotary cell-culture sequencer.
package rotary_cells_pkg;

  typedef enum logic [2:0] {
    IDLE,
    S_SETTLE1,
    LOAD,
    S_SETTLE2,
    MIX,
    S_SETTLE3,
    FLUSH
  } state_t;

  localparam int unsigned TMR_W      = 16;
  localparam int unsigned PUMP_STEPS = 6;

  localparam logic [3:0] MUX_CLOSED = 4'b1111;

  // Packed tables: element [0] is the rightmost entry.
  localparam logic [1:0][3:0] SRC_CODE = {4'b1010, 4'b0101};
  localparam logic [3:0][3:0] DST_CODE = {4'b1010, 4'b1001, 4'b0110, 4'b0101};
  localparam logic [5:0][2:0] PUMP_SEQ = {3'b001, 3'b011, 3'b010,
                                          3'b110, 3'b100, 3'b101};

  // pump = {port4, port5, port6}; 1 = pressurised (closed)
  typedef struct packed {
    logic [3:0] in_mux;
    logic       inlet;
    logic [2:0] pump;
    logic       outlet;
    logic [3:0] out_mux;
  } valve_t;

  localparam valve_t VALVES_CLOSED = '1;

endpackage

// File: rtl/rotary_pump_seq.sv
// Peristaltic step and rotation counter for the mixer ring.
module rotary_pump_seq
  import rotary_cells_pkg::*;
#(
  parameter int unsigned PHASE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] rot,
  output logic [2:0] pat,
  output logic       last
);

  logic [TMR_W-1:0] phase_cnt;
  logic [2:0]       step;
  logic [7:0]       rot_cnt;
  logic             phase_end;
  logic             step_end;

  assign phase_end = (phase_cnt == TMR_W'(PHASE_CYC - 1));
  assign step_end  = (step == 3'(PUMP_STEPS - 1));

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      phase_cnt <= '0;
      step      <= '0;
      rot_cnt   <= '0;
    end else if (phase_end) begin
      phase_cnt <= '0;
      if (step_end) begin
        step    <= '0;
        rot_cnt <= rot_cnt + 8'd1;
      end else begin
        step    <= step + 3'd1;
      end
    end else begin
      phase_cnt <= phase_cnt + TMR_W'(1);
    end
  end

  // Rotation compare widened so a count of 255 never wraps.
  assign last = en && phase_end && step_end &&
                (({1'b0, rot_cnt} + 9'd1) == {1'b0, rot});

  // pat is the pattern for the coming cycle so the valve word can be registered.
  always_comb begin
    pat = PUMP_SEQ[0];
    if (en) begin
      if (phase_end)
        pat = step_end ? PUMP_SEQ[0] : PUMP_SEQ[step + 3'd1];
      else
        pat = PUMP_SEQ[step];
    end
  end

endmodule

// File: rtl/rotary_cells_ctrl.sv
// Pneumatic sequencer for the rotary cell-culture chip: load, mix, flush.
// Optional abort input enabled by defining ROTARY_CELLS_CTRL_ABORT_EN.
module rotary_cells_ctrl
  import rotary_cells_pkg::*;
#(
  parameter int unsigned LOAD_CYC   = 64,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned PHASE_CYC  = 16,
  parameter int unsigned FLUSH_CYC  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_src,
  input  logic [1:0] cmd_trap,
  input  logic [7:0] cmd_rot,
  output logic       busy,
  output logic       done,
  output logic       cb1_1,
  output logic       cb1_2,
  output logic       cb2_1,
  output logic       cb2_2,
  output logic       cb3_1,
  output logic       cb3_2,
  output logic       cb3_3,
  output logic       cb4_1,
  output logic       cb4_2,
  output logic       cb5_1,
  output logic       cb5_2,
  output logic       cb6_1,
  output logic       cb6_2
`ifdef ROTARY_CELLS_CTRL_ABORT_EN
  ,
  input  logic       abort
`endif
);

  state_t           state;
  state_t           next_state;
  logic [TMR_W-1:0] tmr;
  logic             tmr_end;
  logic             src_q;
  logic [1:0]       trap_q;
  logic [7:0]       rot_q;
  valve_t           valves;
  valve_t           valves_d;
  logic             accept;
  logic             abort_req;
  logic             pump_en;
  logic             pump_last;
  logic [2:0]       pump_pat;

  assign cmd_ready = (state == IDLE);
  assign busy      = !cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign pump_en   = (state == MIX);

`ifdef ROTARY_CELLS_CTRL_ABORT_EN
  assign abort_req = abort &&
                     (state inside {S_SETTLE1, LOAD, S_SETTLE2, MIX});
`else
  assign abort_req = 1'b0;
`endif

  rotary_pump_seq #(
    .PHASE_CYC(PHASE_CYC)
  ) u_pump (
    .clk  (clk),
    .rst  (rst),
    .en   (pump_en),
    .rot  (rot_q),
    .pat  (pump_pat),
    .last (pump_last)
  );

  always_comb begin
    tmr_end = 1'b0;
    unique case (state)
      S_SETTLE1, S_SETTLE2, S_SETTLE3: tmr_end = (tmr == TMR_W'(SETTLE_CYC - 1));
      LOAD:                            tmr_end = (tmr == TMR_W'(LOAD_CYC - 1));
      FLUSH:                           tmr_end = (tmr == TMR_W'(FLUSH_CYC - 1));
      default:                         tmr_end = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tmr    <= '0;
      src_q  <= 1'b0;
      trap_q <= '0;
      rot_q  <= '0;
      valves <= VALVES_CLOSED;
      done   <= 1'b0;
    end else begin
      state  <= next_state;
      tmr    <= (next_state != state || state == IDLE) ? '0 : tmr + TMR_W'(1);
      valves <= valves_d;
      done   <= (state == FLUSH) && (next_state == IDLE);
      if (accept) begin
        src_q  <= cmd_src;
        trap_q <= cmd_trap;
        rot_q  <= cmd_rot;
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (accept)  next_state = S_SETTLE1;
      S_SETTLE1: if (tmr_end) next_state = LOAD;
      LOAD:      if (tmr_end) next_state = S_SETTLE2;
      S_SETTLE2: if (tmr_end) next_state = (rot_q == 8'd0) ? S_SETTLE3 : MIX;
      MIX:       if (pump_last) next_state = S_SETTLE3;
      S_SETTLE3: if (tmr_end) next_state = FLUSH;
      FLUSH:     if (tmr_end) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
    if (abort_req)
      next_state = S_SETTLE3;
  end

  // Decoded from next_state so the registered valves line up with the state.
  always_comb begin
    valves_d = VALVES_CLOSED;
    unique case (next_state)
      LOAD: begin
        valves_d.in_mux = SRC_CODE[src_q];
        valves_d.inlet  = 1'b0;
      end
      MIX: begin
        valves_d.pump = pump_pat;
      end
      FLUSH: begin
        valves_d.outlet  = 1'b0;
        valves_d.out_mux = DST_CODE[trap_q];
      end
      default: valves_d = VALVES_CLOSED;
    endcase
  end

  assign {cb1_1, cb1_2, cb2_1, cb2_2} = valves.in_mux;
  assign cb3_1                        = valves.inlet;
  assign {cb4_1, cb4_2, cb3_2}        = valves.pump;
  assign cb3_3                        = valves.outlet;
  assign {cb6_2, cb5_1, cb5_2, cb6_1} = valves.out_mux;

endmodule

// File: tb/tb_rotary_cells_ctrl.sv
// Randomized bench for rotary_cells_ctrl against a per-cycle valve-trace model.
module tb_rotary_cells_ctrl;

  localparam int S  = 8;
  localparam int LD = 64;
  localparam int P  = 16;
  localparam int FL = 64;

  localparam logic [3:0] SRC_TAB  [2] = '{4'b0101, 4'b1010};
  localparam logic [3:0] DST_TAB  [4] = '{4'b0101, 4'b0110, 4'b1001, 4'b1010};
  localparam logic [2:0] PUMP_TAB [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  localparam logic [12:0] CLOSED = 13'h1FFF;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_src, busy, done;
  logic [1:0] cmd_trap;
  logic [7:0] cmd_rot;
  logic cb1_1, cb1_2, cb2_1, cb2_2, cb3_1, cb3_2, cb3_3;
  logic cb4_1, cb4_2, cb5_1, cb5_2, cb6_1, cb6_2;
`ifdef ROTARY_CELLS_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rotary_cells_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_trap(cmd_trap), .cmd_rot(cmd_rot),
    .busy(busy), .done(done),
    .cb1_1(cb1_1), .cb1_2(cb1_2), .cb2_1(cb2_1), .cb2_2(cb2_2),
    .cb3_1(cb3_1), .cb3_2(cb3_2), .cb3_3(cb3_3),
    .cb4_1(cb4_1), .cb4_2(cb4_2), .cb5_1(cb5_1), .cb5_2(cb5_2),
    .cb6_1(cb6_1), .cb6_2(cb6_2)
`ifdef ROTARY_CELLS_CTRL_ABORT_EN
    , .abort(abort)
`endif
  );

  // {input mux, inlet, port4, port5, port6, outlet, output mux}
  logic [12:0] obs;
  assign obs = {cb1_1, cb1_2, cb2_1, cb2_2, cb3_1, cb4_1, cb4_2, cb3_2,
                cb3_3, cb6_2, cb5_1, cb5_2, cb6_1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cmd_len(input int rot, input int abort_at);
    if (abort_at >= 0) return abort_at + S + FL;
    return 3 * S + LD + 6 * P * rot + FL;
  endfunction

  // Expected valve word in busy cycle i (1 = first cycle after acceptance).
  function automatic logic [12:0] exp_word(input int i, input bit src, input bit [1:0] trap,
                                           input int rot, input int abort_at);
    int k;
    logic [12:0] flush_w;
    flush_w = {4'hF, 1'b1, 3'b111, 1'b0, DST_TAB[trap]};
    if (abort_at >= 0 && i > abort_at)
      return (i - abort_at <= S) ? CLOSED : flush_w;
    k = i - 1;
    if (k < S) return CLOSED;
    k -= S;
    if (k < LD) return {SRC_TAB[src], 1'b0, 3'b111, 1'b1, 4'hF};
    k -= LD;
    if (k < S) return CLOSED;
    k -= S;
    if (k < 6 * P * rot) return {4'hF, 1'b1, PUMP_TAB[(k / P) % 6], 1'b1, 4'hF};
    k -= 6 * P * rot;
    if (k < S) return CLOSED;
    return flush_w;
  endfunction

  // Entered and left at a negedge; the done cycle is the exit point, so a
  // following call is accepted on that same done cycle.
  task automatic run_cmd(input bit src, input bit [1:0] trap, input bit [7:0] rot,
                         input bit hold, input int abort_at, input int rst_at);
    int len;
    len = cmd_len(int'(rot), abort_at);
    check("ready_pre", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_src   = src;
    cmd_trap  = trap;
    cmd_rot   = rot;
    @(posedge clk);
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      if (i == 1) begin
        cmd_valid = hold;
        cmd_src   = ~src;
        cmd_trap  = trap + 2'd1;
        cmd_rot   = rot + 8'd1;
      end
      check("word", obs, exp_word(i, src, trap, int'(rot), abort_at));
      check("busy", busy, 1);
      check("ready_busy", cmd_ready, 0);
      check("done_early", done, 0);
`ifdef ROTARY_CELLS_CTRL_ABORT_EN
      abort = (i == abort_at);
`endif
      if (i == rst_at) begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_word", obs, CLOSED);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        return;
      end
    end
    @(negedge clk);
    check("done", done, 1);
    check("done_ready", cmd_ready, 1);
    check("done_busy", busy, 0);
    check("done_word", obs, CLOSED);
    cmd_valid = 1'b0;
`ifdef ROTARY_CELLS_CTRL_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_word", obs, CLOSED);
      check("idle_done", done, 0);
      check("idle_ready", cmd_ready, 1);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_src   = 1'b0;
    cmd_trap  = '0;
    cmd_rot   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_word", obs, CLOSED);
    check("reset_ready", cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 1'b0;
    idle_cycles(2);

    run_cmd(1'b1, 2'd2, 8'd1, 1'b0, -1, -1);
    run_cmd(1'b0, 2'd3, 8'd0, 1'b1, -1, -1);

    for (int n = 0; n < 6; n++) begin
      bit        s, h;
      bit [1:0]  t;
      bit [7:0]  r;
      s = 1'($urandom_range(0, 1));
      t = 2'($urandom_range(0, 3));
      r = 8'($urandom_range(0, 3));
      h = 1'($urandom_range(0, 1));
      run_cmd(s, t, r, h, -1, -1);
      if ($urandom_range(0, 1) == 1)
        idle_cycles(int'($urandom_range(1, 4)));
    end

    run_cmd(1'b0, 2'd1, 8'd3, 1'b0, -1, S + LD + S + 20);
    idle_cycles(300);

`ifdef ROTARY_CELLS_CTRL_ABORT_EN
    run_cmd(1'b0, 2'd1, 8'd2, 1'b0, S + 10, -1);
    idle_cycles(2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
